// File: rtl/reg_file.sv
// reg_file: WIDTH x DEPTH register file, one write and two read ports.
// Byte-lane writes, optional hardwired-zero r0 and write-to-read bypass.
module reg_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]  raddr_a,
  output logic [WIDTH-1:0]   rdata_a,
  input  logic [ADDR_W-1:0]  raddr_b,
  output logic [WIDTH-1:0]   rdata_b
);

  localparam int unsigned NB = WIDTH / 8;

  logic [WIDTH-1:0] r_mem  [DEPTH];
  logic [WIDTH-1:0] w_view [DEPTH];
  logic [DEPTH-1:0] w_wsel;
  logic [WIDTH-1:0] w_wmask;

  // Expand byte strobes into a per-bit mask
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < NB; b++)
      w_wmask[8*b +: 8] = {8{wstrb[b]}};
  end

  // One-hot write select; out-of-range or unknown addresses select nothing
  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < DEPTH; i++)
      w_wsel[i] = we
                && (waddr == ADDR_W'(i))
                && !(ZERO_REG && (i == 0));
  end

  // Storage: asynchronous clear, masked byte merge on write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_wsel[i])
          r_mem[i] <= (r_mem[i] & ~w_wmask)
                    | (wdata & w_wmask);
    end
  end

  // Per-register read view, write-first when forwarding is enabled
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_view[i] = r_mem[i];
      if (BYPASS && w_wsel[i])
        w_view[i] = (r_mem[i] & ~w_wmask)
                  | (wdata & w_wmask);
    end
  end

  // Read muxes; unmatched addresses read 0, reset forces 0
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i))
        rdata_a = w_view[i];
      if (raddr_b == ADDR_W'(i))
        rdata_b = w_view[i];
    end
    if (!rst_n) begin
      rdata_a = '0;
      rdata_b = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vector table plus hand sequences
// for reset, hold, bypass contrast and out-of-range depth.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] a0, b0, a1, b1, a2, b2;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .we(we),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(a0),
    .raddr_b(raddr_b), .rdata_b(b0)
  );

  reg_file #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(a1),
    .raddr_b(raddr_b), .rdata_b(b1)
  );

  reg_file #(.DEPTH(24)) dut_d24 (
    .clk(clk), .rst_n(rst_n), .we(we),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(a2),
    .raddr_b(raddr_b), .rdata_b(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic        w,
                       input logic [4:0]  wa,
                       input logic [31:0] wd,
                       input logic [3:0]  ws,
                       input logic [4:0]  ra,
                       input logic [4:0]  rb);
    @(negedge clk);
    we      = w;
    waddr   = wa;
    wdata   = wd;
    wstrb   = ws;
    raddr_a = ra;
    raddr_b = rb;
    #2;
  endtask

  initial begin
    tv[0]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd0, 5'd5,
               32'h0,        32'h0};
    tv[1]  = '{1'b1, 5'd3,  32'h11223344, 4'hF, 5'd3, 5'd4,
               32'h11223344, 32'h0};
    tv[2]  = '{1'b1, 5'd3,  32'hAABBCCDD, 4'h5, 5'd3, 5'd3,
               32'h11BB33DD, 32'h11BB33DD};
    tv[3]  = '{1'b0, 5'd3,  32'h0,        4'hF, 5'd3, 5'd3,
               32'h11BB33DD, 32'h11BB33DD};
    tv[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0, 5'd0,
               32'h0,        32'h0};
    tv[5]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd0, 5'd0,
               32'h0,        32'h0};
    tv[6]  = '{1'b1, 5'd1,  32'h1,        4'hF, 5'd1, 5'd31,
               32'h1,        32'h0};
    tv[7]  = '{1'b1, 5'd31, 32'h80000000, 4'hF, 5'd1, 5'd31,
               32'h1,        32'h80000000};
    tv[8]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd1, 5'd31,
               32'h1,        32'h80000000};
    tv[9]  = '{1'b1, 5'd7,  32'hCAFEF00D, 4'hF, 5'd7, 5'd6,
               32'hCAFEF00D, 32'h0};
    tv[10] = '{1'b1, 5'd7,  32'h0,        4'h0, 5'd7, 5'd7,
               32'hCAFEF00D, 32'hCAFEF00D};
    tv[11] = '{1'b0, 5'd7,  32'h0,        4'h0, 5'd7, 5'd3,
               32'hCAFEF00D, 32'h11BB33DD};
    tv[12] = '{1'b1, 5'd9,  32'h12345678, 4'hF, 5'd9, 5'd3,
               32'h12345678, 32'h11BB33DD};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd0);
    chk("reset_a", a0, 32'h0);
    chk("reset_b", b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].ws,
            tv[i].ra, tv[i].rb);
      chk($sformatf("vec%0d_a", i), a0, tv[i].ea);
      chk($sformatf("vec%0d_b", i), b0, tv[i].eb);
    end

    for (int k = 0; k < 4; k++) begin
      drive(1'b0, (k % 2) ? 5'd9 : 5'd10,
            32'hF0F0F0F0 ^ k, 4'hF, 5'd9, 5'd10);
      chk($sformatf("hold%0d_r9", k), a0, 32'h12345678);
      chk($sformatf("hold%0d_r10", k), b0, 32'h0);
    end

    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd7);
    chk("nb_r0_ordinary", a1, 32'hFFFFFFFF);
    chk("nb_r7", b1, 32'hCAFEF00D);
    chk("zero_after", a0, 32'h0);

    drive(1'b1, 5'd7, 32'h5A5A5A5A, 4'hF, 5'd7, 5'd0);
    chk("byp_new", a0, 32'h5A5A5A5A);
    chk("nb_old", a1, 32'hCAFEF00D);
    drive(1'b0, 5'd7, 32'h0, 4'h0, 5'd7, 5'd0);
    chk("nb_after_edge", a1, 32'h5A5A5A5A);

    drive(1'b1, 5'd28, 32'h77777777, 4'hF, 5'd28, 5'd31);
    chk("d24_oor_byp", a2, 32'h0);
    chk("d24_r31", b2, 32'h0);
    chk("d32_byp28", a0, 32'h77777777);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd28, 5'd12);
    chk("d24_oor_read", a2, 32'h0);
    chk("d24_alias12", b2, 32'h0);
    chk("d32_r28", a0, 32'h77777777);
    raddr_a = 5'd4;
    raddr_b = 5'd3;
    #1;
    chk("d24_alias4", a2, 32'h0);
    chk("d24_r3", b2, 32'h11BB33DD);

    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd3);
    drive(1'b0, 5'd5, 32'h0, 4'h0, 5'd5, 5'd3);
    chk("pre_reset_r5", a0, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_r5", a0, 32'h0);
    chk("async_r3", b0, 32'h0);
    chk("async_nb_r5", a1, 32'h0);

    drive(1'b1, 5'd5, 32'h11111111, 4'hF, 5'd5, 5'd3);
    chk("rst_no_byp", a0, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    wdata   = 32'h22222222;
    wstrb   = 4'h1;
    #2;
    chk("rel_byp", a0, 32'h00000022);
    drive(1'b0, 5'd5, 32'h0, 4'h0, 5'd5, 5'd3);
    chk("rel_first_wr", a0, 32'h00000022);
    chk("rel_r3", b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
